// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - iterative ALU driving the status-flag register (optional macro ALU_STICKY_OVF_EN adds ovf_clr/ovf_sticky)
module alu_flag_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ALU_STICKY_OVF_EN
    input  logic             ovf_clr,
    output logic             ovf_sticky,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             sout,
    output logic             vout,
    output logic             zout,
    output logic             update
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    localparam int         CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam int         MSB  = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [CW-1:0]        count;

    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_v;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_next;
    logic                 accept;
    logic                 fin_single;
    logic                 fin_mul;
    logic                 next_v;
    logic                 ovf_set;

    // Single-cycle datapath; CMP shares the SUB difference and overflow rule
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff;
                alu_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SHL:  alu_res = a << b[3:0];
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: upper half accumulates, whole product shifts right
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {mul_sum, prod[WIDTH-1:1]};
    end

    // Completion detection, shared by the flag registers and the sticky bit
    always_comb begin
        accept     = start && ((state == IDLE) || (state == DONE));
        fin_single = accept && (op != OP_MUL);
        fin_mul    = (state == EXEC) && (count == LAST);
        next_v     = fin_mul ? (|prod_next[2*WIDTH-1:WIDTH]) : alu_v;
        ovf_set    = (fin_single || fin_mul) && next_v;
    end

    // Control FSM with registered result, flags and strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            sout   <= 1'b0;
            vout   <= 1'b0;
            zout   <= 1'b0;
            mcand  <= '0;
            prod   <= '0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept) begin
                        if (op == OP_MUL) begin
                            mcand <= a;
                            prod  <= {{WIDTH{1'b0}}, b};
                            count <= '0;
                            busy  <= 1'b1;
                            state <= EXEC;
                        end else begin
                            if (op != OP_CMP) begin
                                result <= alu_res;
                            end
                            sout  <= alu_res[MSB];
                            zout  <= (alu_res == '0);
                            vout  <= alu_v;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                EXEC: begin
                    prod  <= prod_next;
                    count <= count + 1'b1;
                    if (fin_mul) begin
                        result <= prod_next[WIDTH-1:0];
                        sout   <= prod_next[MSB];
                        zout   <= (prod_next[WIDTH-1:0] == '0);
                        vout   <= next_v;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign update = done;

`ifdef ALU_STICKY_OVF_EN
    // Sticky overflow: set wins over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (ovf_set) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = ovf_set;
`endif

endmodule

// File: tb/tb_alu_flag_gen.sv
// tb/tb_alu_flag_gen.sv - scoreboard testbench for alu_flag_gen
module tb_alu_flag_gen;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] r;
        logic         s;
        logic         v;
        logic         z;
    } exp_t;

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         s;
        logic         v;
        logic         z;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, sout, vout, zout, update;
    logic [W-1:0] result;
`ifdef ALU_STICKY_OVF_EN
    logic         ovf_clr = 1'b0;
    logic         ovf_sticky;
`endif

    int   errors = 0;
    int   checks = 0;
    int   dones  = 0;
    exp_t q[$];
    exp_t mon_e;
    vec_t vecs[8];

    alu_flag_gen #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
`ifdef ALU_STICKY_OVF_EN
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
`endif
        .busy       (busy),
        .done       (done),
        .result     (result),
        .sout       (sout),
        .vout       (vout),
        .zout       (zout),
        .update     (update)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_res(input logic [W-1:0] r, input logic s, input logic v, input logic z);
        exp_t e;
        e.r = r; e.s = s; e.v = v; e.z = z;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int k = 0;
        while (!done && k < limit) begin
            step(1);
            k++;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    // Monitor: every done pops one expected response
    always @(negedge clk) begin
        if (!reset) begin
            chk("update_eq_done", {31'd0, update}, {31'd0, done});
            if (done) begin
                dones++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got result %0h expected no done", result);
                end else begin
                    mon_e = q.pop_front();
                    chk("result", {16'd0, result}, {16'd0, mon_e.r});
                    chk("sout", {31'd0, sout}, {31'd0, mon_e.s});
                    chk("vout", {31'd0, vout}, {31'd0, mon_e.v});
                    chk("zout", {31'd0, zout}, {31'd0, mon_e.z});
                end
            end
        end
    end

    initial begin
        int d0;
        vecs[0] = '{3'b000, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{3'b100, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{3'b011, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{3'b101, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3'b101, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0};

        // reset state
        step(2);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, sout, vout, zout}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;
        step(1);

        // ADD signed overflow
        expect_res(16'h8000, 1'b1, 1'b1, 1'b0);
        drive(3'b000, 16'h7FFF, 16'h0001);
        chk("add_latency", {31'd0, done}, 32'd1);
        step(1);

        // asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        chk("arst_result", {16'd0, result}, 32'd0);
        chk("arst_flags", {29'd0, sout, vout, zout}, 32'd0);
        chk("arst_busy_done", {30'd0, busy, done}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(1);

        // SUB to zero, then CMP keeps result
        expect_res(16'h0000, 1'b0, 1'b0, 1'b1);
        drive(3'b001, 16'h0005, 16'h0005);
        step(1);
        expect_res(16'h0000, 1'b1, 1'b0, 1'b0);
        drive(3'b111, 16'h0003, 16'h0007);
        chk("cmp_busy", {31'd0, busy}, 32'd0);
        step(2);

        // back-to-back single-cycle ops
        d0 = dones;
        foreach (vecs[i]) begin
            expect_res(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].z);
            drive(vecs[i].o, vecs[i].x, vecs[i].y);
            chk("b2b_done", {31'd0, done}, 32'd1);
        end
        step(1);
        chk("b2b_count", dones - d0, 32'd8);
        step(1);

        // MUL timing, with an ignored start in cycle 5
        expect_res(16'h03A8, 1'b0, 1'b0, 1'b0);
        drive(3'b110, 16'h0012, 16'h0034);
        for (int c = 1; c <= 16; c++) begin
            chk("mul_busy", {31'd0, busy}, 32'd1);
            chk("mul_no_done", {31'd0, done}, 32'd0);
            if (c == 6 || c == 16) chk("mul_hold", {16'd0, result}, 32'h0008);
            if (c == 5) begin
                start = 1'b1; op = 3'b000; a = 16'h1111; b = 16'h2222;
            end else begin
                start = 1'b0;
            end
            step(1);
        end
        start = 1'b0;
        chk("mul_done_c17", {31'd0, done}, 32'd1);
        chk("mul_busy_c17", {31'd0, busy}, 32'd0);
        step(1);
        chk("mul_done_pulse", {31'd0, done}, 32'd0);

        // MUL overflow, sticky flag
        expect_res(16'h0000, 1'b0, 1'b1, 1'b1);
        drive(3'b110, 16'h0100, 16'h0100);
        wait_done(40, "mul_ovf_timeout");
`ifdef ALU_STICKY_OVF_EN
        chk("sticky_set", {31'd0, ovf_sticky}, 32'd1);
        expect_res(16'h0002, 1'b0, 1'b0, 1'b0);
        drive(3'b000, 16'h0001, 16'h0001);
        step(1);
        chk("sticky_hold", {31'd0, ovf_sticky}, 32'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("sticky_clr", {31'd0, ovf_sticky}, 32'd0);
        expect_res(16'h8000, 1'b1, 1'b1, 1'b0);
        ovf_clr = 1'b1;
        drive(3'b000, 16'h7FFF, 16'h0001);
        ovf_clr = 1'b0;
        chk("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
`endif
        step(2);

        // reset during MUL, then a fresh ADD
        drive(3'b110, 16'h0003, 16'h0005);
        step(7);
        #2 reset = 1'b1;
        #1;
        chk("mulrst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("mulrst_result", {16'd0, result}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(20);
        chk("mulrst_idle", {30'd0, busy, done}, 32'd0);
        expect_res(16'h0005, 1'b0, 1'b0, 1'b0);
        drive(3'b000, 16'h0002, 16'h0003);
        chk("post_rst_latency", {31'd0, done}, 32'd1);
        step(2);

        chk("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
